// File: rtl/usb_link_pkg.sv
// rtl/usb_link_pkg.sv - shared USB link constants: block size, pad byte, packer state encoding
// Contents: tx_state_e (IDLE/SEND/PAD/COMMIT), BLOCK_BYTES_DEFAULT, PAD_BYTE_DEFAULT, lane_byte()
package usb_link_pkg;

  localparam int         BLOCK_BYTES_DEFAULT = 256;
  localparam logic [7:0] PAD_BYTE_DEFAULT    = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND   = 2'd1,
    ST_PAD    = 2'd2,
    ST_COMMIT = 2'd3
  } tx_state_e;

  // Byte select within a 32-bit word; lane 0 is [7:0] and goes out first.
  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/result_tx_packer_if.sv
// rtl/result_tx_packer_if.sv - result word input and USB TX byte bus bundle
// master: computation unit / driver side; slave: result_tx_packer
//   res_data/res_valid/res_ready : 32-bit result word handshake
//   frame_complete               : flush request pulse
//   FIFO_tx_BT                   : driver has room for one block
//   FIFO_tx_enable/FIFO_tx_din   : byte strobe and data
//   FIFO_tx_ready                : block committed pulse
//   tx_busy/frame_sent           : status
interface result_tx_packer_if;
  logic [31:0] res_data;
  logic        res_valid;
  logic        res_ready;
  logic        frame_complete;
  logic        FIFO_tx_BT;
  logic        FIFO_tx_enable;
  logic [7:0]  FIFO_tx_din;
  logic        FIFO_tx_ready;
  logic        tx_busy;
  logic        frame_sent;

  modport master (
    output res_data, res_valid, frame_complete, FIFO_tx_BT,
    input  res_ready, FIFO_tx_enable, FIFO_tx_din, FIFO_tx_ready, tx_busy, frame_sent
  );

  modport slave (
    input  res_data, res_valid, frame_complete, FIFO_tx_BT,
    output res_ready, FIFO_tx_enable, FIFO_tx_din, FIFO_tx_ready, tx_busy, frame_sent
  );
endinterface

// File: rtl/sync_word_fifo.sv
// rtl/sync_word_fifo.sv - single-clock word FIFO with registered write and show-ahead read
// Ports: clk, rst_n (async active-low), wr_en/wr_data, rd_en/rd_data (head word),
//        empty, full, count (0..DEPTH)
module sync_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_wr, do_rd;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/result_tx_packer.sv
// rtl/result_tx_packer.sv - buffers 32-bit results and serialises them LSB-first into USB TX blocks
// Ports: clk, rst_n (async active-low), bus (result_tx_packer_if.slave):
//   result words in via res_data/res_valid/res_ready, flush via frame_complete,
//   bytes out via FIFO_tx_enable/FIFO_tx_din, FIFO_tx_ready per block, tx_busy, frame_sent
module result_tx_packer
  import usb_link_pkg::*;
#(
  parameter int         DEPTH       = 16,
  parameter int         BLOCK_BYTES = BLOCK_BYTES_DEFAULT,
  parameter logic [7:0] PAD_BYTE    = PAD_BYTE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  result_tx_packer_if.slave  bus
);
  localparam int              CW        = $clog2(BLOCK_BYTES);
  localparam int              PW        = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   LAST_BYTE = CW'(BLOCK_BYTES - 1);

  logic [31:0]   head_word;
  logic          fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic [PW-1:0] fifo_count;

  tx_state_e     state_q, state_d;
  logic [CW-1:0] byte_cnt_q, byte_cnt_d;
  logic [1:0]    lane_q, lane_d;
  logic          flush_pending_q, flush_pending_d;
  logic          pad_commit_q, pad_commit_d;
  logic          tx_enable_q, tx_enable_d;
  logic [7:0]    tx_din_q, tx_din_d;
  logic          tx_ready_q, tx_ready_d;
  logic          frame_sent_q, frame_sent_d;
  logic          issue_data, clear_flush;

  assign bus.res_ready = (fifo_count < PW'(DEPTH));
  assign fifo_push     = bus.res_valid && !fifo_full;

  sync_word_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_push),
    .wr_data (bus.res_data),
    .rd_en   (fifo_pop),
    .rd_data (head_word),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      byte_cnt_q      <= '0;
      lane_q          <= '0;
      flush_pending_q <= 1'b0;
      pad_commit_q    <= 1'b0;
      tx_enable_q     <= 1'b0;
      tx_din_q        <= '0;
      tx_ready_q      <= 1'b0;
      frame_sent_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      byte_cnt_q      <= byte_cnt_d;
      lane_q          <= lane_d;
      flush_pending_q <= flush_pending_d;
      pad_commit_q    <= pad_commit_d;
      tx_enable_q     <= tx_enable_d;
      tx_din_q        <= tx_din_d;
      tx_ready_q      <= tx_ready_d;
      frame_sent_q    <= frame_sent_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    lane_d       = lane_q;
    pad_commit_d = pad_commit_q;
    tx_enable_d  = 1'b0;
    tx_din_d     = tx_din_q;
    tx_ready_d   = 1'b0;
    frame_sent_d = 1'b0;
    fifo_pop     = 1'b0;
    issue_data   = 1'b0;
    clear_flush  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The first byte is issued in the same cycle the block is granted,
        // so the registered strobe appears one cycle after BT is seen.
        if (!fifo_empty && bus.FIFO_tx_BT) begin
          issue_data = 1'b1;
          state_d    = ST_SEND;
        end else if (flush_pending_q && fifo_empty && (byte_cnt_q == '0)) begin
          frame_sent_d = 1'b1;
          clear_flush  = 1'b1;
        end
      end
      ST_SEND: begin
        // Words are only popped on lane 3, so an empty FIFO here is always
        // at a word boundary.
        if (!fifo_empty)          issue_data = 1'b1;
        else if (flush_pending_q) state_d    = ST_PAD;
      end
      ST_PAD: begin
        tx_enable_d = 1'b1;
        tx_din_d    = PAD_BYTE;
        byte_cnt_d  = byte_cnt_q + CW'(1);
        if (byte_cnt_q == LAST_BYTE) begin
          state_d      = ST_COMMIT;
          pad_commit_d = 1'b1;
        end
      end
      ST_COMMIT: begin
        tx_ready_d   = 1'b1;
        pad_commit_d = 1'b0;
        state_d      = ST_IDLE;
        if (pad_commit_q) begin
          frame_sent_d = 1'b1;
          clear_flush  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (issue_data) begin
      tx_enable_d = 1'b1;
      tx_din_d    = lane_byte(head_word, lane_q);
      lane_d      = lane_q + 2'd1;
      byte_cnt_d  = byte_cnt_q + CW'(1);
      fifo_pop    = (lane_q == 2'd3);
      if (byte_cnt_q == LAST_BYTE) state_d = ST_COMMIT;
    end

    // A clear in the same cycle as a new request wins; a request while one
    // is already pending has nothing further to do.
    if (clear_flush)             flush_pending_d = 1'b0;
    else if (bus.frame_complete) flush_pending_d = 1'b1;
    else                         flush_pending_d = flush_pending_q;
  end

  assign bus.FIFO_tx_enable = tx_enable_q;
  assign bus.FIFO_tx_din    = tx_din_q;
  assign bus.FIFO_tx_ready  = tx_ready_q;
  assign bus.tx_busy        = (state_q != ST_IDLE);
  assign bus.frame_sent     = frame_sent_q;
endmodule

// File: tb/tb_result_tx_packer.sv
// tb/tb_result_tx_packer.sv - self-checking bench for result_tx_packer
module tb_result_tx_packer;
  localparam int BB = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  result_tx_packer_if bus();

  result_tx_packer #(.DEPTH(16), .BLOCK_BYTES(BB), .PAD_BYTE(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed output events, sampled mid-cycle.
  logic [7:0] got_b[$];
  int         got_c[$];
  int         rdy_c[$];
  int         fs_c[$];
  // Reference byte stream built from the words actually accepted.
  logic [7:0] exp_b[$];

  always @(negedge clk) begin
    if (bus.FIFO_tx_enable === 1'b1) begin
      got_b.push_back(bus.FIFO_tx_din);
      got_c.push_back(cyc);
    end
    if (bus.FIFO_tx_ready === 1'b1) rdy_c.push_back(cyc);
    if (bus.frame_sent === 1'b1)    fs_c.push_back(cyc);
  end

  function automatic void model_word(input logic [31:0] w);
    logic [31:0] t = w;
    for (int k = 0; k < 4; k++) begin
      exp_b.push_back(t[7:0]);
      t = t >> 8;
    end
  endfunction

  function automatic void model_flush();
    while ((exp_b.size() % BB) != 0) exp_b.push_back(8'h00);
  endfunction

  function automatic int first_diff();
    int n = (got_b.size() < exp_b.size()) ? got_b.size() : exp_b.size();
    for (int i = 0; i < n; i++) if (got_b[i] !== exp_b[i]) return i;
    if (got_b.size() != exp_b.size()) return n;
    return -1;
  endfunction

  function automatic string diff_str(input int i);
    logic [7:0] g = 8'hxx;
    logic [7:0] e = 8'hxx;
    if (i < got_b.size()) g = got_b[i];
    if (i < exp_b.size()) e = exp_b[i];
    return $sformatf("idx=%0d got=%02h exp=%02h got_len=%0d exp_len=%0d",
                     i, g, e, got_b.size(), exp_b.size());
  endfunction

  function automatic int last_byte_cyc();
    return (got_c.size() > 0) ? got_c[got_c.size()-1] : -100;
  endfunction

  task automatic clear_all();
    got_b.delete(); got_c.delete(); rdy_c.delete(); fs_c.delete(); exp_b.delete();
  endtask

  task automatic push_word(input logic [31:0] w, input bit fc, output int pcyc);
    bit ok;
    int n = 0;
    bus.res_data  = w;
    bus.res_valid = 1'b1;
    do begin
      ok = bus.res_ready;
      bus.frame_complete = fc && ok;
      pcyc = cyc;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 3000);
    bus.res_valid      = 1'b0;
    bus.frame_complete = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL push_accept word=%08h res_ready stayed 0 for %0d cycles, required 1", w, n);
    end else begin
      model_word(w);
    end
  endtask

  task automatic pulse_fc();
    bus.frame_complete = 1'b1;
    @(posedge clk); #1;
    bus.frame_complete = 1'b0;
    model_flush();
  endtask

  task automatic wait_quiet(output bit timed_out);
    int quiet = 0;
    int n = 0;
    while (quiet < 20 && n < 4000) begin
      @(posedge clk); #1;
      n++;
      quiet = bus.tx_busy ? 0 : quiet + 1;
    end
    timed_out = (quiet < 20);
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    obs = {bus.res_ready, bus.FIFO_tx_enable, bus.FIFO_tx_din, bus.FIFO_tx_ready,
           bus.tx_busy, bus.frame_sent};
    checks++;
    if (obs !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs got=%013b required=1000000000000", obs);
    end
  endtask

  task automatic test_full_block();
    int pc, p0, d;
    bit to;
    clear_all();
    bus.FIFO_tx_BT = 1'b1;
    for (int i = 0; i < 64; i++) begin
      push_word(32'h03020100 + 32'h04040404 * i, 1'b0, pc);
      if (i == 0) p0 = pc;
    end
    wait_quiet(to);
    checks++;
    if (to) begin failures++; $display("FAIL full_timeout tx_busy stuck at 1, required 0"); end
    d = first_diff();
    checks++;
    if (d != -1) begin failures++; $display("FAIL full_bytes %s", diff_str(d)); end
    checks++;
    if (got_c.size() == 0 || got_c[0] != p0 + 2) begin
      failures++;
      $display("FAIL full_latency first_enable_cyc=%0d required=%0d", last_byte_cyc(), p0 + 2);
    end
    checks++;
    if (got_c.size() != BB || last_byte_cyc() - got_c[0] != BB - 1) begin
      failures++;
      $display("FAIL full_contiguous n=%0d span=%0d required n=256 span=255",
               got_c.size(), (got_c.size() > 0) ? last_byte_cyc() - got_c[0] : -1);
    end
    checks++;
    if (rdy_c.size() != 1 || rdy_c[0] != last_byte_cyc() + 1) begin
      failures++;
      $display("FAIL full_ready pulses=%0d first=%0d required 1 at %0d",
               rdy_c.size(), (rdy_c.size() > 0) ? rdy_c[0] : -1, last_byte_cyc() + 1);
    end
    checks++;
    if (fs_c.size() != 0 || bus.tx_busy !== 1'b0) begin
      failures++;
      $display("FAIL full_idle frame_sent=%0d tx_busy=%b required 0 and 0", fs_c.size(), bus.tx_busy);
    end
  endtask

  task automatic test_flush_pad();
    int pc, d;
    bit to;
    logic [31:0] words[3] = '{32'hDDCCBBAA, 32'h44332211, 32'h0000BEEF};
    clear_all();
    for (int i = 0; i < 3; i++) push_word(words[i], 1'b0, pc);
    pulse_fc();
    wait_quiet(to);
    checks++;
    if (to) begin failures++; $display("FAIL pad_timeout tx_busy stuck at 1, required 0"); end
    d = first_diff();
    checks++;
    if (d != -1) begin failures++; $display("FAIL pad_bytes %s", diff_str(d)); end
    checks++;
    if (rdy_c.size() != 1 || fs_c.size() != 1 || rdy_c[0] != fs_c[0] || rdy_c[0] != last_byte_cyc() + 1) begin
      failures++;
      $display("FAIL pad_commit ready=%0d frame_sent=%0d ready_cyc=%0d fs_cyc=%0d required one each at %0d",
               rdy_c.size(), fs_c.size(), (rdy_c.size() > 0) ? rdy_c[0] : -1,
               (fs_c.size() > 0) ? fs_c[0] : -1, last_byte_cyc() + 1);
    end
  endtask

  task automatic test_backpressure();
    int pc, d, bt_cyc;
    bit to;
    clear_all();
    bus.FIFO_tx_BT = 1'b0;
    for (int i = 0; i < 16; i++) push_word($urandom, 1'b0, pc);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (got_b.size() != 0 || bus.res_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_hold enables=%0d res_ready=%b required 0 and 0", got_b.size(), bus.res_ready);
    end
    bus.FIFO_tx_BT = 1'b1;
    bt_cyc = cyc;
    for (int i = 0; i < 48; i++) begin
      push_word($urandom, 1'b0, pc);
      if (i == 8) bus.FIFO_tx_BT = 1'b0;
    end
    wait_quiet(to);
    bus.FIFO_tx_BT = 1'b1;
    checks++;
    if (to) begin failures++; $display("FAIL bp_timeout tx_busy stuck at 1, required 0"); end
    checks++;
    if (got_c.size() == 0 || got_c[0] != bt_cyc + 1) begin
      failures++;
      $display("FAIL bp_start first_enable_cyc=%0d required=%0d",
               (got_c.size() > 0) ? got_c[0] : -1, bt_cyc + 1);
    end
    d = first_diff();
    checks++;
    if (d != -1) begin failures++; $display("FAIL bp_bytes %s", diff_str(d)); end
    checks++;
    if (got_c.size() != BB || last_byte_cyc() - got_c[0] != BB - 1 || rdy_c.size() != 1) begin
      failures++;
      $display("FAIL bp_uninterrupted n=%0d ready=%0d required n=256 contiguous ready=1",
               got_c.size(), rdy_c.size());
    end
  endtask

  task automatic test_gap();
    int pc, d;
    bit to;
    clear_all();
    for (int i = 0; i < 2; i++) push_word($urandom, 1'b0, pc);
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 62; i++) push_word($urandom, 1'b0, pc);
    wait_quiet(to);
    checks++;
    if (to) begin failures++; $display("FAIL gap_timeout tx_busy stuck at 1, required 0"); end
    d = first_diff();
    checks++;
    if (d != -1) begin failures++; $display("FAIL gap_bytes %s", diff_str(d)); end
    checks++;
    if (got_c.size() < 9 || got_c[8] - got_c[7] < 2) begin
      failures++;
      $display("FAIL gap_stall n=%0d required a stall between byte 7 and 8", got_c.size());
    end
    checks++;
    if (rdy_c.size() != 1 || fs_c.size() != 0) begin
      failures++;
      $display("FAIL gap_ready ready=%0d frame_sent=%0d required 1 and 0", rdy_c.size(), fs_c.size());
    end
  endtask

  task automatic test_exact_multiple();
    int pc, d;
    bit to;
    clear_all();
    for (int i = 0; i < 64; i++) push_word($urandom, 1'b0, pc);
    pulse_fc();
    wait_quiet(to);
    checks++;
    if (to) begin failures++; $display("FAIL exact_timeout tx_busy stuck at 1, required 0"); end
    d = first_diff();
    checks++;
    if (d != -1) begin failures++; $display("FAIL exact_bytes %s", diff_str(d)); end
    checks++;
    if (rdy_c.size() != 1 || fs_c.size() != 1 || fs_c[0] != rdy_c[0] + 1) begin
      failures++;
      $display("FAIL exact_frame_sent ready=%0d fs=%0d ready_cyc=%0d fs_cyc=%0d required fs one cycle after ready",
               rdy_c.size(), fs_c.size(), (rdy_c.size() > 0) ? rdy_c[0] : -1,
               (fs_c.size() > 0) ? fs_c[0] : -1);
    end
  endtask

  task automatic test_reset_mid_block();
    int pc, d, n;
    bit to;
    logic [12:0] obs;
    clear_all();
    for (int i = 0; i < 30; i++) push_word($urandom, 1'b0, pc);
    n = 0;
    while (got_b.size() < 100 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    obs = {bus.res_ready, bus.FIFO_tx_enable, bus.FIFO_tx_din, bus.FIFO_tx_ready,
           bus.tx_busy, bus.frame_sent};
    checks++;
    if (got_b.size() < 100 || obs !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL midrst_outputs bytes=%0d got=%013b required >=100 bytes and 1000000000000",
               got_b.size(), obs);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rdy_c.size() != 0) begin
      failures++;
      $display("FAIL midrst_no_ready ready=%0d required 0", rdy_c.size());
    end
    clear_all();
    for (int i = 0; i < 64; i++) push_word(32'h03020100 + 32'h04040404 * i, 1'b0, pc);
    wait_quiet(to);
    d = first_diff();
    checks++;
    if (to || d != -1 || rdy_c.size() != 1) begin
      failures++;
      $display("FAIL midrst_clean_block timeout=%0b ready=%0d %s", to, rdy_c.size(), diff_str(d));
    end
  endtask

  task automatic test_random_frames();
    int pc, d, nw, exp_rdy, exp_fs;
    bit to, fc_same;
    for (int f = 0; f < 6; f++) begin
      clear_all();
      nw      = (f == 2) ? 128 : $urandom_range(1, 70);
      fc_same = $urandom_range(0, 1);
      for (int i = 0; i < nw; i++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        push_word($urandom, (i == nw - 1) && fc_same, pc);
      end
      if (fc_same) model_flush();
      else         pulse_fc();
      wait_quiet(to);
      exp_rdy = exp_b.size() / BB;
      d = first_diff();
      checks++;
      if (to || d != -1) begin
        failures++;
        $display("FAIL rand_bytes frame=%0d words=%0d timeout=%0b %s", f, nw, to, diff_str(d));
      end
      exp_fs = (rdy_c.size() > 0) ? rdy_c[rdy_c.size()-1] + (((nw * 4) % BB == 0) ? 1 : 0) : -1;
      checks++;
      if (rdy_c.size() != exp_rdy || fs_c.size() != 1 || fs_c[0] != exp_fs) begin
        failures++;
        $display("FAIL rand_pulses frame=%0d ready=%0d fs=%0d fs_cyc=%0d required ready=%0d fs=1 at %0d",
                 f, rdy_c.size(), fs_c.size(), (fs_c.size() > 0) ? fs_c[0] : -1, exp_rdy, exp_fs);
      end
    end
  endtask

  initial begin
    bus.res_data       = '0;
    bus.res_valid      = 1'b0;
    bus.frame_complete = 1'b0;
    bus.FIFO_tx_BT     = 1'b1;
    rst_n              = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_full_block();
    test_flush_pad();
    test_backpressure();
    test_gap();
    test_exact_multiple();
    test_reset_mid_block();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/result_tx_packer.md
Name: result_tx_packer

Overview:
- Return path of the USB link: accepts 32-bit result words from the computation unit and buffers them in a small word FIFO.
- Serialises each word LSB-byte-first into the USB driver's transmit byte interface, in fixed-size blocks.
- Uses the same block handshake the driver applies to receive traffic; a frame_complete flush pads the final partial block.
- Sits between the computation unit and the USB driver TX FIFO; it is the transmit counterpart of the frame-loading memory interface.

Parameters:
DEPTH, 16, word FIFO depth in 32-bit words (power of 2, >=2)
BLOCK_BYTES, 256, bytes per USB transmit block (multiple of 4, power of 2)
PAD_BYTE, 8'h00, filler byte used when flushing a partial block

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
res_data  in  32  result word, byte0 = [7:0] sent first
res_valid  in  1  res_data valid this cycle
res_ready  out  1  word FIFO can accept (count < DEPTH)
frame_complete  in  1  single-cycle pulse: last result of frame pushed, flush requested
FIFO_tx_BT  in  1  driver TX buffer has room for one full block
FIFO_tx_enable  out  1  byte strobe, registered
FIFO_tx_din  out  8  byte data, valid when FIFO_tx_enable=1
FIFO_tx_ready  out  1  one-cycle pulse: block of BLOCK_BYTES committed
tx_busy  out  1  high in any state other than IDLE
frame_sent  out  1  one-cycle pulse: flush finished, all frame bytes committed

Behaviour:
- Reset (async, rst_n=0): FIFO empty, res_ready=1, FIFO_tx_enable=0, FIFO_tx_din=0, FIFO_tx_ready=0, tx_busy=0, frame_sent=0, byte_cnt=0, lane=0, flush_pending=0, state=IDLE. Reset mid-block drops the partial block; no FIFO_tx_ready is issued.
- Push: word accepted when res_valid & res_ready. A push while full is ignored (caller must honour res_ready). Simultaneous push and pop is allowed when not full; count is unchanged.
- FIFO is registered; a word pushed at cycle t is poppable at t+1.
- State IDLE:
  - If FIFO non-empty and FIFO_tx_BT=1, go to SEND.
  - Else if flush_pending, FIFO empty and byte_cnt=0, pulse frame_sent, clear flush_pending and stay in IDLE.
  - FIFO_tx_BT is sampled only here; it is ignored mid-block.
- State SEND:
  - Each cycle with a word at the FIFO head: FIFO_tx_enable=1, FIFO_tx_din = head byte[lane]; lane increments and byte_cnt increments.
  - On lane 3 the word is popped.
  - If the FIFO is empty at a word boundary and flush_pending=0: stall with enable=0 and keep state.
  - If the FIFO is empty at a word boundary and flush_pending=1: go to PAD.
  - When byte_cnt reaches BLOCK_BYTES-1 on an issued byte: go to COMMIT and wrap byte_cnt to 0.
- State PAD: emit PAD_BYTE one per cycle with enable=1 until byte_cnt reaches BLOCK_BYTES-1, then go to COMMIT.
- State COMMIT:
  - FIFO_tx_ready=1 for exactly one cycle.
  - If the block was completed in PAD, also pulse frame_sent in the same cycle and clear flush_pending.
  - Then go to IDLE.
- Latency: with state IDLE, FIFO empty and FIFO_tx_BT=1, the first byte enable appears 2 cycles after the push cycle.
- Throughput: one byte per cycle steady state; no bubbles between words while the FIFO is non-empty.
- frame_complete:
  - Sets flush_pending.
  - A pulse while flush_pending=1 is ignored.
  - A pulse in the same cycle as the final push is valid; the flush waits for that word to drain.
- Exact multiple: if the frame ends exactly on a block boundary, there is no PAD; frame_sent pulses from IDLE one cycle after COMMIT.
- Widths: byte_cnt is clog2(BLOCK_BYTES) bits and wraps naturally; lane is 2 bits; the FIFO pointer width is clog2(DEPTH)+1.

Decomposition:
- Shared package (usb_link_pkg): the state encoding constants (IDLE, SEND, PAD, COMMIT), BLOCK_BYTES_DEFAULT=256 and PAD_BYTE_DEFAULT. The receive-side memory interface reuses the block size from this package.
- One natural sub-module: sync_word_fifo (parameterised WIDTH/DEPTH, async active-low reset, outputs empty, full and count). The packer FSM and serialiser stay in result_tx_packer.

Test Plan:
1. After reset, push 64 words 0x03020100+0x04040404*i with FIFO_tx_BT=1 -> 256 consecutive bytes 0x00,0x01,...,0xFF. FIFO_tx_ready pulses once, the cycle after the last byte. tx_busy returns to 0.
2. Push 3 words {0xDDCCBBAA, 0x44332211, 0x0000BEEF}, then pulse frame_complete -> 12 data bytes AA BB CC DD 11 22 33 44 EF BE 00 00, then 244 bytes of 0x00. Exactly 256 enables, then FIFO_tx_ready and frame_sent both pulse in the same cycle.
3. Hold FIFO_tx_BT=0 while pushing 16 words -> no enables, and res_ready=0 after the 16th push. Raise BT -> transmission starts 1 cycle later. Drop BT mid-block -> transmission continues uninterrupted.
4. Push 2 words, then wait 10 cycles, then push 62 more -> enable is low for the gap and no pad occurs. The total is exactly 256 bytes, with a single FIFO_tx_ready.
5. Send 64 words, then pulse frame_complete -> no PAD. frame_sent pulses 1 cycle after FIFO_tx_ready, and no extra bytes are sent.
6. Assert rst_n=0 after 100 bytes of a block -> all outputs return to reset values immediately. After release, a new 64-word push produces a clean full block.
